// File: rtl/gin_bus_ctrl.sv
// gin_bus_ctrl: global-input-network bus controller.
// Packet FIFO with broadcast issue FSM, plus round-robin psum return arbiter.
module gin_bus_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int TAG_WIDTH  = 4,
   parameter int NUM_MC     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [1:0]                     in_type,
   input  logic [TAG_WIDTH-1:0]           in_tag,
   input  logic [2*DATA_WIDTH-1:0]        in_data,
   input  logic [NUM_MC-1:0]              caster_ready,
   output logic [2:0]                     caster_en,
   output logic [TAG_WIDTH-1:0]           bus_tag,
   output logic [DATA_WIDTH-1:0]          ifmap_data_B2M,
   output logic [DATA_WIDTH-1:0]          fltr_data_B2M,
   output logic [2*DATA_WIDTH-1:0]        psum_data_B2M,
   input  logic [NUM_MC-1:0]              caster_valid,
   input  logic [NUM_MC*2*DATA_WIDTH-1:0] psum_data_M2B,
   output logic [NUM_MC-1:0]              caster_ack,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [2*DATA_WIDTH-1:0]        out_data,
   output logic [$clog2(NUM_MC)-1:0]      out_id,
   output logic                           err_type
);

   localparam int PSW = 2*DATA_WIDTH;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int IDW = $clog2(NUM_MC);

   typedef struct packed {
      logic [1:0]           ptype;
      logic [TAG_WIDTH-1:0] tag;
      logic [PSW-1:0]       data;
   } pkt_t;

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   pkt_t            mem [FIFO_DEPTH];
   pkt_t            head;
   logic [PW-1:0]   wptr;
   logic [PW-1:0]   rptr;
   logic [CW-1:0]   count;
   logic            full;
   logic            empty;
   logic            wr;
   logic            rd;

   state_t          state_q;
   state_t          state_d;
   logic            issue;
   logic [2:0]      en_dec;

   logic [TAG_WIDTH-1:0]  tag_q;
   logic [DATA_WIDTH-1:0] ifmap_q;
   logic [DATA_WIDTH-1:0] fltr_q;
   logic [PSW-1:0]        psum_q;
   logic                  err_q;

   logic [NUM_MC-1:0] elig;
   logic              free;
   logic              hit;
   logic [IDW-1:0]    gnt;
   logic [IDW-1:0]    rr_q;
   logic [IDW-1:0]    rr_nxt;

   // ---------------- input FIFO ----------------
   assign full     = (count == CW'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !rst && !full;
   assign wr       = in_valid && in_ready;
   assign rd       = issue;
   assign head     = mem[rptr];

   always_ff @(posedge clk) begin
      if (wr) begin
         mem[wptr] <= '{ptype: in_type, tag: in_tag, data: in_data};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr) begin
            wptr <= wptr + 1'b1;
         end
         if (rd) begin
            rptr <= rptr + 1'b1;
         end
         count <= count + CW'(wr) - CW'(rd);
      end
   end

   // ---------------- issue FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!empty && &caster_ready) begin
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = IDLE;
      endcase
   end

   always_comb begin
      en_dec = 3'b000;
      unique case (head.ptype)
         2'd0: en_dec = 3'b001;
         2'd1: en_dec = 3'b010;
         2'd2: en_dec = 3'b100;
         2'd3: en_dec = 3'b000;
      endcase
   end

   assign issue = (state_q == ISSUE);

   // Live value only during the issue cycle; otherwise the lane holds.
   assign caster_en      = issue ? en_dec : 3'b000;
   assign bus_tag        = (issue && |en_dec) ? head.tag : tag_q;
   assign ifmap_data_B2M = (issue && en_dec[0])
                         ? head.data[DATA_WIDTH-1:0] : ifmap_q;
   assign fltr_data_B2M  = (issue && en_dec[1])
                         ? head.data[DATA_WIDTH-1:0] : fltr_q;
   assign psum_data_B2M  = (issue && en_dec[2]) ? head.data : psum_q;
   assign err_type       = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q   <= '0;
         ifmap_q <= '0;
         fltr_q  <= '0;
         psum_q  <= '0;
         err_q   <= 1'b0;
      end else if (issue) begin
         if (|en_dec) begin
            tag_q <= head.tag;
         end
         if (en_dec[0]) begin
            ifmap_q <= head.data[DATA_WIDTH-1:0];
         end
         if (en_dec[1]) begin
            fltr_q <= head.data[DATA_WIDTH-1:0];
         end
         if (en_dec[2]) begin
            psum_q <= head.data;
         end
         if (head.ptype == 2'd3) begin
            err_q <= 1'b1;
         end
      end
   end

   // ---------------- result arbiter ----------------
   // An MC acked last cycle still shows valid; it must not win again.
   assign elig = caster_valid & ~caster_ack;
   assign free = !out_valid || out_ready;

   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      hit = 1'b0;
      for (int k = NUM_MC-1; k >= 0; k--) begin
         j = int'(rr_q) + k;
         if (j >= NUM_MC) begin
            j = j - NUM_MC;
         end
         if (elig[j]) begin
            hit = 1'b1;
            gnt = IDW'(j);
         end
      end
   end

   assign rr_nxt = (gnt == IDW'(NUM_MC-1)) ? '0 : gnt + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_id     <= '0;
         caster_ack <= '0;
         rr_q       <= '0;
      end else begin
         caster_ack <= '0;
         if (free) begin
            if (hit) begin
               out_valid  <= 1'b1;
               out_data   <= psum_data_M2B[int'(gnt)*PSW +: PSW];
               out_id     <= gnt;
               caster_ack <= NUM_MC'(1) << gnt;
               rr_q       <= rr_nxt;
            end else begin
               out_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_gin_bus_ctrl.sv
// tb_gin_bus_ctrl: directed phases plus random traffic for gin_bus_ctrl,
// checked every cycle against a queue-based reference model.
module tb_gin_bus_ctrl;

   localparam int DW  = 16;
   localparam int TW  = 4;
   localparam int NM  = 4;
   localparam int FD  = 4;
   localparam int PSW = 2*DW;
   localparam int IDW = $clog2(NM);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_type;
   logic [TW-1:0]    in_tag;
   logic [PSW-1:0]   in_data;
   logic [NM-1:0]    caster_ready;
   logic [2:0]       caster_en;
   logic [TW-1:0]    bus_tag;
   logic [DW-1:0]    ifmap_data_B2M;
   logic [DW-1:0]    fltr_data_B2M;
   logic [PSW-1:0]   psum_data_B2M;
   logic [NM-1:0]    caster_valid;
   logic [NM*PSW-1:0] psum_data_M2B;
   logic [NM-1:0]    caster_ack;
   logic             out_valid;
   logic             out_ready;
   logic [PSW-1:0]   out_data;
   logic [IDW-1:0]   out_id;
   logic             err_type;

   int n_assert = 0;
   int n_fail   = 0;
   int n_pushed = 0;
   int n_pulses = 0;

   typedef struct {
      logic [1:0]    t;
      logic [TW-1:0] tag;
      logic [PSW-1:0] d;
   } mpkt_t;

   mpkt_t          q[$];
   bit             m_issuing;
   logic [DW-1:0]  m_if;
   logic [DW-1:0]  m_fl;
   logic [PSW-1:0] m_ps;
   logic [TW-1:0]  m_tag;
   bit             m_err;
   bit             m_ov;
   logic [PSW-1:0] m_od;
   int             m_oid;
   logic [NM-1:0]  m_ack;
   int             m_rr;

   gin_bus_ctrl #(
      .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_MC(NM), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_type(in_type), .in_tag(in_tag), .in_data(in_data),
      .caster_ready(caster_ready), .caster_en(caster_en),
      .bus_tag(bus_tag),
      .ifmap_data_B2M(ifmap_data_B2M),
      .fltr_data_B2M(fltr_data_B2M),
      .psum_data_B2M(psum_data_B2M),
      .caster_valid(caster_valid),
      .psum_data_M2B(psum_data_M2B),
      .caster_ack(caster_ack),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_id(out_id),
      .err_type(err_type)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [PSW-1:0] obs,
                      input logic [PSW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model advance for one rising edge, using the inputs held across it.
   task automatic model_edge();
      int            sz;
      bit            push;
      bit            nxt;
      mpkt_t         h;
      logic [NM-1:0] cand;
      logic [NM-1:0] new_ack;
      int            best;
      int            bestd;
      int            d;
      if (rst) begin
         q.delete();
         m_issuing = 0;
         m_if = '0; m_fl = '0; m_ps = '0; m_tag = '0; m_err = 0;
         m_ov = 0; m_od = '0; m_oid = 0; m_ack = '0; m_rr = 0;
         return;
      end
      sz   = q.size();
      push = in_valid && (sz < FD);
      nxt  = !m_issuing && (sz > 0) && (caster_ready == '1);
      if (m_issuing) begin
         h = q.pop_front();
         case (h.t)
            2'd0: begin m_if = h.d[DW-1:0]; m_tag = h.tag; end
            2'd1: begin m_fl = h.d[DW-1:0]; m_tag = h.tag; end
            2'd2: begin m_ps = h.d;         m_tag = h.tag; end
            default: m_err = 1;
         endcase
      end
      if (push) begin
         q.push_back('{t: in_type, tag: in_tag, d: in_data});
         n_pushed++;
      end
      m_issuing = nxt;
      cand    = caster_valid & ~m_ack;
      new_ack = '0;
      if (!m_ov || out_ready) begin
         if (cand != '0) begin
            best  = 0;
            bestd = NM;
            for (int i = 0; i < NM; i++) begin
               d = (i - m_rr + NM) % NM;
               if (cand[i] && d < bestd) begin
                  bestd = d;
                  best  = i;
               end
            end
            m_ov  = 1;
            m_od  = psum_data_M2B[best*PSW +: PSW];
            m_oid = best;
            new_ack[best] = 1'b1;
            m_rr  = (best + 1) % NM;
         end else begin
            m_ov = 0;
         end
      end
      m_ack = new_ack;
   endtask

   task automatic check_all();
      logic [2:0]     e_en;
      logic [TW-1:0]  e_tag;
      logic [DW-1:0]  e_if;
      logic [DW-1:0]  e_fl;
      logic [PSW-1:0] e_ps;
      mpkt_t          h;
      e_en = 3'b000; e_tag = m_tag; e_if = m_if; e_fl = m_fl; e_ps = m_ps;
      if (m_issuing) begin
         h = q[0];
         case (h.t)
            2'd0: begin e_en = 3'b001; e_tag = h.tag; e_if = h.d[DW-1:0]; end
            2'd1: begin e_en = 3'b010; e_tag = h.tag; e_fl = h.d[DW-1:0]; end
            2'd2: begin e_en = 3'b100; e_tag = h.tag; e_ps = h.d; end
            default: ;
         endcase
      end
      if (caster_en != 3'b000) n_pulses++;
      chk("in_ready", PSW'(in_ready), PSW'(!rst && q.size() < FD));
      chk("caster_en", PSW'(caster_en), PSW'(e_en));
      chk("bus_tag", PSW'(bus_tag), PSW'(e_tag));
      chk("ifmap_lane", PSW'(ifmap_data_B2M), PSW'(e_if));
      chk("fltr_lane", PSW'(fltr_data_B2M), PSW'(e_fl));
      chk("psum_lane", psum_data_B2M, e_ps);
      chk("err_type", PSW'(err_type), PSW'(m_err));
      chk("out_valid", PSW'(out_valid), PSW'(m_ov));
      chk("out_data", out_data, m_od);
      chk("out_id", PSW'(out_id), PSW'(m_oid));
      chk("caster_ack", PSW'(caster_ack), PSW'(m_ack));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic push1(input logic [1:0] t, input logic [TW-1:0] tg,
                        input logic [PSW-1:0] d);
      in_valid = 1'b1;
      in_type  = t;
      in_tag   = tg;
      in_data  = d;
      step();
   endtask

   initial begin
      int start;
      rst = 1'b1; in_valid = 1'b1; in_type = 2'd0; in_tag = 4'h9;
      in_data = 32'hDEAD_BEEF; caster_ready = '1; caster_valid = '0;
      out_ready = 1'b1;
      psum_data_M2B = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);

      // Reset with in_valid held high
      step();
      step();
      chk("rst_in_ready", PSW'(in_ready), '0);
      rst = 1'b0; in_valid = 1'b0;
      step();

      // Basic issue of the three lane types
      n_pulses = 0;
      push1(2'd0, 4'd3, 32'h0000_1234);
      push1(2'd1, 4'd5, 32'h0000_00AB);
      push1(2'd2, 4'd7, 32'h0001_0002);
      in_valid = 1'b0;
      repeat (6) step();
      chk("issue_pulses", PSW'(n_pulses), PSW'(3));

      // Backpressure from one not-ready caster
      caster_ready = 4'b1011;
      start = n_pushed;
      for (int c = 0; c < 40 && (n_pushed - start) < 5; c++) begin
         if (c == 8) caster_ready = 4'b1111;
         push1(2'($urandom_range(0, 2)), 4'($urandom()), $urandom());
      end
      chk("bp_pushes", PSW'(n_pushed - start), PSW'(5));
      in_valid = 1'b0;
      repeat (12) step();

      // Illegal type between two ifmaps
      n_pulses = 0;
      push1(2'd0, 4'd1, 32'h0000_1111);
      push1(2'd3, 4'd2, 32'h0000_2222);
      push1(2'd0, 4'd4, 32'h0000_3333);
      in_valid = 1'b0;
      repeat (10) step();
      chk("illegal_pulses", PSW'(n_pulses), PSW'(2));
      chk("err_sticky", PSW'(err_type), PSW'(1));

      // Round-robin with all casters valid
      psum_data_M2B = {$urandom(), $urandom(), $urandom(), $urandom()};
      caster_valid = 4'b1111;
      out_ready = 1'b1;
      repeat (8) step();
      caster_valid = '0;
      repeat (2) step();

      // Output stall
      out_ready = 1'b0;
      caster_valid = 4'b0100;
      repeat (5) step();
      out_ready = 1'b1;
      repeat (2) step();
      caster_valid = '0;
      repeat (3) step();

      // Random traffic including occasional reset
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 49) == 0);
         in_valid = $urandom_range(0, 1) == 1;
         in_type = ($urandom_range(0, 7) == 0) ? 2'd3
                   : 2'($urandom_range(0, 2));
         in_tag = 4'($urandom());
         in_data = $urandom();
         caster_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
         caster_valid = 4'($urandom());
         out_ready = $urandom_range(0, 2) != 0;
         psum_data_M2B = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
      end
      rst = 1'b0; in_valid = 1'b0; caster_ready = 4'hF;
      caster_valid = '0; out_ready = 1'b1;
      repeat (12) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
